spinner_quad_emu: RTL and testbench
===================================

// Module: spinner_quad_emu
// PURPOSE
//  Converts relative pointer motion (PS/2 mouse X delta) and digital joystick left/right into AB quadrature spinner signals.
//  NUM_CH independent channels. Sits between hps_io and the arcade core's spinner inputs.
//  Successor to the single-channel inline mouse-to-spinner logic:
//    - parametrised widths and rates
//    - saturating accumulator
//    - busy status
//  Pacing uses an internal step prescaler, not a separate PLL clock.
// PARAMETERS
//  NUM_CH        2      number of spinner channels
//  DX_W          9      signed delta width per channel
//  ACC_W         12     signed pending-step accumulator width (ACC_W > DX_W)
//  STEP_DIV      12     clk_sys cycles per quadrature step tick (>=2)
//  POLL_DIV      96000  clk_sys cycles per joystick reload (~8 ms at 12 MHz)
//  JOY_STEP      4      accumulator load for held joystick, normal speed
//  JOY_STEP_FAST 9      accumulator load when joy_fast is held
//  POS_W         16     absolute position width (SPINNER_ABSPOS_EN only)
// PORTS
//  clk_sys    in   1           system clock, all logic rising-edge
//  reset      in   1           asynchronous, active-low reset
//  mouse_tgl  in   NUM_CH      per-channel packet toggle; every change = new delta
//  mouse_dx   in   NUM_CH*DX_W signed delta per channel, valid when mouse_tgl changes
//  joy_pos    in   NUM_CH      held: spin positive (right)
//  joy_neg    in   NUM_CH      held: spin negative (left)
//  joy_fast   in   NUM_CH      held: use JOY_STEP_FAST
//  quad       out  2*NUM_CH    {A,B} per channel, ch0 in [1:0]
//  busy       out  NUM_CH      channel accumulator nonzero
//  abs_pos    out  NUM_CH*POS_W signed step count (SPINNER_ABSPOS_EN only)
// BEHAVIOUR
//  Reset values
//    - quad = 2'b11, busy = 0, acc = 0, counters = 0, abs_pos = 0.
//    - Toggle history is armed on the first post-reset cycle; that cycle never yields an event.
//  Step prescaler
//    - Shared counter 0..STEP_DIV-1; step_tick is high when it wraps.
//  Per channel, priority order per cycle (only one action applies)
//    1. Joystick load: fires when poll_cnt == POLL_DIV-1 while joy_pos|joy_neg is held.
//       - acc <= +/-(joy_fast ? JOY_STEP_FAST : JOY_STEP).
//       - poll_cnt <= 0.
//       - joy_pos wins when both joy_pos and joy_neg are held.
//       - Releasing both clears poll_cnt the next cycle.
//    2. Mouse event: fires on a mouse_tgl edge, 1 cycle after it is registered.
//       - dx is sign-extended to ACC_W.
//       - If acc==0 or sign(acc)==sign(dx): acc <= sat(acc+dx), saturating to +(2^(ACC_W-1)-1) / -(2^(ACC_W-1)-1).
//       - Else (reversal): acc <= dx; pending opposite motion is discarded.
//       - dx==0 leaves acc unchanged.
//    3. Step: fires on step_tick when acc != 0.
//       - acc moves one toward 0.
//       - quad advances one Gray state:
//           positive: 00->10->11->01->00
//           negative: 00->01->11->10->00
//       - A step blocked by action 1 or 2 is lost, not deferred.
//  Latency and outputs
//    - First quad change after a mouse event: at the next step_tick, at most STEP_DIV+1 cycles.
//    - quad and busy are registered; busy = (acc != 0) from the registered acc.
//    - Exactly one bit of quad changes per step; quad never changes without a step.
//  Reset mid-operation: acc dropped, quad returns to 11 immediately (async).
//  Toggles arriving faster than one per cycle are not supported; each edge seen is one event.
// CONFIGURATION
//  SPINNER_ABSPOS_EN
//    - Defined: abs_pos port exists; it increments/decrements with each quad step and wraps modulo 2^POS_W.
//    - Undefined: port and counters are absent; all other behaviour is identical.
// STRUCTURE
//  Package spinner_pkg
//    - typedef quad_t (logic [1:0]).
//    - QUAD_RESET = 2'b11.
//    - function quad_next(quad_t q, logic neg).
//    - function sat_add for ACC_W.
//  Sub-module spinner_channel
//    - One instance per channel via generate.
//    - Holds acc, poll_cnt, toggle history, quad and optional abs_pos.
//  Top
//    - Holds the shared step prescaler.
//    - Slices the packed buses.
// TESTING
//  T1 mouse positive
//    - Stimulus: ch0 dx=+3, one toggle.
//    - Expect: quad 11->01->00->10 on three consecutive step_ticks, busy low after the third, no further change.
//  T2 reversal
//    - Stimulus: ch0 dx=+100, then after 5 steps dx=-2.
//    - Expect: acc becomes -2, exactly 2 negative-direction steps, then idle.
//  T3 saturation
//    - Stimulus: ACC_W=12, 20 toggles of dx=+255 with no steps (STEP_DIV large).
//    - Expect: acc=2047 (not wrapped), busy high.
//  T4 joystick
//    - Stimulus: joy_pos held with joy_fast.
//    - Expect: acc=9 after POLL_DIV cycles, reloaded every POLL_DIV.
//    - Stimulus: joy_pos+joy_neg held together.
//    - Expect: positive motion.
//    - Stimulus: release.
//    - Expect: remaining steps drain, then no motion.
//  T5 collisions/reset
//    - Stimulus: toggle on the same cycle as a joystick load.
//    - Expect: joystick value loaded, mouse delta ignored.
//    - Stimulus: reset asserted mid-burst.
//    - Expect: quad=11 and busy=0 at once.
//    - Stimulus: mouse_tgl high at reset release.
//    - Expect: no event.
//  T6 SPINNER_ABSPOS_EN
//    - Stimulus: POS_W=4, 17 positive steps.
//    - Expect: abs_pos=1.
//    - Stimulus: 2 negative steps.
//    - Expect: abs_pos=-1 (4'hF).

Source files
------------

// File: rtl/spinner_pkg.sv
// Shared types and helpers for the quadrature spinner emulator.
// The optional absolute position counter is enabled by SPINNER_ABSPOS_EN.
package spinner_pkg;

    typedef logic [1:0] quad_t;

    localparam quad_t QUAD_RESET = 2'b11;

    // Positive direction walks 00->10->11->01->00; negative walks it backwards.
    function automatic quad_t quad_next(input quad_t q, input logic neg);
        quad_t r;
        case (q)
            2'b00:   r = neg ? 2'b01 : 2'b10;
            2'b10:   r = neg ? 2'b00 : 2'b11;
            2'b11:   r = neg ? 2'b10 : 2'b01;
            default: r = neg ? 2'b11 : 2'b00;
        endcase
        return r;
    endfunction

    // Symmetric clamp: the most negative code is never produced.
    function automatic int sat_add(input int a, input int b, input int acc_w);
        int lim;
        int s;
        lim = (1 << (acc_w - 1)) - 1;
        s = a + b;
        if (s > lim) begin
            s = lim;
        end else if (s < -lim) begin
            s = -lim;
        end
        return s;
    endfunction

endpackage

// File: rtl/spinner_channel.sv
// One spinner channel: pending-step accumulator, joystick poll timer and quadrature output.
// SPINNER_ABSPOS_EN adds a wrapping absolute step counter.
module spinner_channel
    import spinner_pkg::*;
#(
    parameter int DX_W          = 9,
    parameter int ACC_W         = 12,
    parameter int POLL_DIV      = 96000,
    parameter int JOY_STEP      = 4,
    parameter int JOY_STEP_FAST = 9
`ifdef SPINNER_ABSPOS_EN
    ,
    parameter int POS_W         = 16
`endif
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic            step_tick,
    input  logic            mouse_tgl,
    input  logic [DX_W-1:0] mouse_dx,
    input  logic            joy_pos,
    input  logic            joy_neg,
    input  logic            joy_fast,
    output quad_t           quad,
    output logic            busy
`ifdef SPINNER_ABSPOS_EN
    ,
    output logic [POS_W-1:0] abs_pos
`endif
);

    localparam int                      PC_W      = $clog2(POLL_DIV + 1);
    localparam logic [PC_W-1:0]         POLL_LAST = PC_W'(POLL_DIV - 1);
    localparam logic signed [ACC_W-1:0] ACC_ONE   = ACC_W'(1);

    logic                    armed_q;
    logic                    tgl_q;
    logic                    tgl_prev_q;
    logic [DX_W-1:0]         dx_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic [PC_W-1:0]         poll_q;
    logic [PC_W-1:0]         poll_d;
    quad_t                   quad_q;
    quad_t                   quad_d;
    logic                    busy_q;

    logic signed [ACC_W-1:0] dx_ext;
    logic signed [ACC_W-1:0] load_mag;
    logic                    joy_held;
    logic                    joy_load;
    logic                    mouse_evt;
    logic                    do_step;

    assign dx_ext    = {{(ACC_W-DX_W){dx_q[DX_W-1]}}, dx_q};
    assign load_mag  = joy_fast ? ACC_W'(JOY_STEP_FAST) : ACC_W'(JOY_STEP);
    assign joy_held  = joy_pos | joy_neg;
    assign joy_load  = joy_held && (poll_q == POLL_LAST);
    assign mouse_evt = armed_q && (tgl_q != tgl_prev_q);
    // A step that collides with a load or a mouse event is dropped, not queued.
    assign do_step   = step_tick && (acc_q != '0) && !joy_load && !mouse_evt;

    always_comb begin
        acc_d  = acc_q;
        quad_d = quad_q;
        poll_d = (joy_held && !joy_load) ? poll_q + PC_W'(1) : '0;
        if (joy_load) begin
            acc_d = joy_pos ? load_mag : -load_mag;
        end else if (mouse_evt) begin
            if (dx_ext == '0) begin
                acc_d = acc_q;
            end else if ((acc_q == '0) || (acc_q[ACC_W-1] == dx_ext[ACC_W-1])) begin
                acc_d = ACC_W'(sat_add(int'(acc_q), int'(dx_ext), ACC_W));
            end else begin
                acc_d = dx_ext;
            end
        end else if (do_step) begin
            acc_d  = acc_q[ACC_W-1] ? acc_q + ACC_ONE : acc_q - ACC_ONE;
            quad_d = quad_next(quad_q, acc_q[ACC_W-1]);
        end
    end

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            armed_q    <= 1'b0;
            tgl_q      <= 1'b0;
            tgl_prev_q <= 1'b0;
            dx_q       <= '0;
            acc_q      <= '0;
            poll_q     <= '0;
            quad_q     <= QUAD_RESET;
            busy_q     <= 1'b0;
        end else begin
            // Until armed, both history stages load the live toggle so no edge is seen.
            armed_q    <= 1'b1;
            tgl_q      <= mouse_tgl;
            tgl_prev_q <= armed_q ? tgl_q : mouse_tgl;
            dx_q       <= mouse_dx;
            acc_q      <= acc_d;
            poll_q     <= poll_d;
            quad_q     <= quad_d;
            busy_q     <= (acc_d != '0);
        end
    end

    assign quad = quad_q;
    assign busy = busy_q;

`ifdef SPINNER_ABSPOS_EN
    logic [POS_W-1:0] pos_q;

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            pos_q <= '0;
        end else if (do_step) begin
            pos_q <= acc_q[ACC_W-1] ? pos_q - POS_W'(1) : pos_q + POS_W'(1);
        end
    end

    assign abs_pos = pos_q;
`endif

endmodule

// File: rtl/spinner_quad_emu.sv
// Mouse/joystick to AB quadrature spinner converter, NUM_CH channels with a shared step prescaler.
// Define SPINNER_ABSPOS_EN to expose the abs_pos step counters.
module spinner_quad_emu
    import spinner_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int DX_W          = 9,
    parameter int ACC_W         = 12,
    parameter int STEP_DIV      = 12,
    parameter int POLL_DIV      = 96000,
    parameter int JOY_STEP      = 4,
    parameter int JOY_STEP_FAST = 9
`ifdef SPINNER_ABSPOS_EN
    ,
    parameter int POS_W         = 16
`endif
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic [NUM_CH-1:0]      mouse_tgl,
    input  logic [NUM_CH*DX_W-1:0] mouse_dx,
    input  logic [NUM_CH-1:0]      joy_pos,
    input  logic [NUM_CH-1:0]      joy_neg,
    input  logic [NUM_CH-1:0]      joy_fast,
    output logic [2*NUM_CH-1:0]    quad,
    output logic [NUM_CH-1:0]      busy
`ifdef SPINNER_ABSPOS_EN
    ,
    output logic [NUM_CH*POS_W-1:0] abs_pos
`endif
);

    localparam int              SD_W      = $clog2(STEP_DIV);
    localparam logic [SD_W-1:0] STEP_LAST = SD_W'(STEP_DIV - 1);

    logic [SD_W-1:0] div_q;
    logic [SD_W-1:0] div_d;
    logic            step_tick;

    assign step_tick = (div_q == STEP_LAST);
    assign div_d     = step_tick ? '0 : div_q + SD_W'(1);

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            quad_t ch_quad;

            spinner_channel #(
                .DX_W          (DX_W),
                .ACC_W         (ACC_W),
                .POLL_DIV      (POLL_DIV),
                .JOY_STEP      (JOY_STEP),
                .JOY_STEP_FAST (JOY_STEP_FAST)
`ifdef SPINNER_ABSPOS_EN
                ,
                .POS_W         (POS_W)
`endif
            ) u_ch (
                .clk_sys   (clk_sys),
                .reset     (reset),
                .step_tick (step_tick),
                .mouse_tgl (mouse_tgl[gi]),
                .mouse_dx  (mouse_dx[gi*DX_W +: DX_W]),
                .joy_pos   (joy_pos[gi]),
                .joy_neg   (joy_neg[gi]),
                .joy_fast  (joy_fast[gi]),
                .quad      (ch_quad),
                .busy      (busy[gi])
`ifdef SPINNER_ABSPOS_EN
                ,
                .abs_pos   (abs_pos[gi*POS_W +: POS_W])
`endif
            );

            assign quad[2*gi +: 2] = ch_quad;
        end
    endgenerate

endmodule

// File: tb/tb_spinner_quad_emu.sv
// Self-checking bench for spinner_quad_emu: vector table, directed corner sequences and
// randomized traffic against a per-cycle behavioural model. Define SPINNER_ABSPOS_EN to cover abs_pos.
module tb_spinner_quad_emu;

    localparam int NUM_CH        = 2;
    localparam int DX_W          = 9;
    localparam int ACC_W         = 12;
    localparam int STEP_DIV      = 12;
    localparam int POLL_DIV      = 200;
    localparam int JOY_STEP      = 4;
    localparam int JOY_STEP_FAST = 9;
    localparam int ACC_LIM       = (1 << (ACC_W - 1)) - 1;
`ifdef SPINNER_ABSPOS_EN
    localparam int POS_W         = 4;
`endif

    logic                   clk_sys   = 1'b0;
    logic                   rst_n     = 1'b1;
    logic [NUM_CH-1:0]      mouse_tgl = '0;
    logic [NUM_CH*DX_W-1:0] mouse_dx  = '0;
    logic [NUM_CH-1:0]      joy_pos   = '0;
    logic [NUM_CH-1:0]      joy_neg   = '0;
    logic [NUM_CH-1:0]      joy_fast  = '0;
    logic [2*NUM_CH-1:0]    quad;
    logic [NUM_CH-1:0]      busy;
`ifdef SPINNER_ABSPOS_EN
    logic [NUM_CH*POS_W-1:0] abs_pos;
`endif

    always #5 clk_sys = ~clk_sys;

    spinner_quad_emu #(
        .NUM_CH        (NUM_CH),
        .DX_W          (DX_W),
        .ACC_W         (ACC_W),
        .STEP_DIV      (STEP_DIV),
        .POLL_DIV      (POLL_DIV),
        .JOY_STEP      (JOY_STEP),
        .JOY_STEP_FAST (JOY_STEP_FAST)
`ifdef SPINNER_ABSPOS_EN
        ,
        .POS_W         (POS_W)
`endif
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (rst_n),
        .mouse_tgl (mouse_tgl),
        .mouse_dx  (mouse_dx),
        .joy_pos   (joy_pos),
        .joy_neg   (joy_neg),
        .joy_fast  (joy_fast),
        .quad      (quad),
        .busy      (busy)
`ifdef SPINNER_ABSPOS_EN
        ,
        .abs_pos   (abs_pos)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: signed pending steps, net step position, held-joystick age,
    // and the toggle/dx samples taken on the previous two edges.
    int   m_acc   [NUM_CH];
    int   m_pos   [NUM_CH];
    int   m_hold  [NUM_CH];
    int   m_dx1   [NUM_CH];
    logic m_t1    [NUM_CH];
    logic m_t2    [NUM_CH];
    int   m_edges;

    int          obs_steps [NUM_CH];
    int          obs_net   [NUM_CH];
    logic [1:0]  prev_q    [NUM_CH];
    logic [1:0]  gray      [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    typedef struct {
        int         ch;
        int         dx;
        int         steps;
        logic [1:0] fin;
    } vec_t;
    vec_t vecs [7];

    function automatic int qidx(input logic [1:0] q);
        case (q)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < NUM_CH; c++) begin
            m_acc[c]     = 0;
            m_pos[c]     = 0;
            m_hold[c]    = 0;
            m_dx1[c]     = 0;
            m_t1[c]      = 1'b0;
            m_t2[c]      = 1'b0;
            obs_steps[c] = 0;
            obs_net[c]   = 0;
            prev_q[c]    = 2'b11;
        end
        m_edges = 0;
    endtask

    task automatic model_edge();
        bit stick;
        stick = (m_edges % STEP_DIV) == (STEP_DIV - 1);
        for (int c = 0; c < NUM_CH; c++) begin
            bit held, load, evt;
            int amt, s;
            held = joy_pos[c] | joy_neg[c];
            load = held && (m_hold[c] == POLL_DIV - 1);
            evt  = (m_edges >= 2) && (m_t1[c] != m_t2[c]);
            m_hold[c] = (held && !load) ? m_hold[c] + 1 : 0;
            if (load) begin
                amt = joy_fast[c] ? JOY_STEP_FAST : JOY_STEP;
                m_acc[c] = joy_pos[c] ? amt : -amt;
            end else if (evt) begin
                if (m_dx1[c] != 0) begin
                    if (m_acc[c] == 0 || ((m_acc[c] > 0) == (m_dx1[c] > 0))) begin
                        s = m_acc[c] + m_dx1[c];
                        if (s > ACC_LIM) s = ACC_LIM;
                        if (s < -ACC_LIM) s = -ACC_LIM;
                        m_acc[c] = s;
                    end else begin
                        m_acc[c] = m_dx1[c];
                    end
                end
            end else if (stick && m_acc[c] != 0) begin
                s = (m_acc[c] > 0) ? 1 : -1;
                m_pos[c] += s;
                m_acc[c] -= s;
            end
            m_t2[c]  = m_t1[c];
            m_t1[c]  = mouse_tgl[c];
            m_dx1[c] = int'($signed(mouse_dx[c*DX_W +: DX_W]));
        end
        m_edges++;
    endtask

    task automatic check_outputs();
        logic [2*NUM_CH-1:0] exp_quad;
        logic [NUM_CH-1:0]   exp_busy;
        for (int c = 0; c < NUM_CH; c++) begin
            exp_quad[2*c +: 2] = gray[((2 + m_pos[c]) % 4 + 4) % 4];
            exp_busy[c]        = (m_acc[c] != 0);
        end
        check("quad", int'(quad), int'(exp_quad));
        check("busy", int'(busy), int'(exp_busy));
`ifdef SPINNER_ABSPOS_EN
        for (int c = 0; c < NUM_CH; c++) begin
            logic [POS_W-1:0] ep;
            ep = POS_W'(m_pos[c]);
            check("abs_pos", int'(abs_pos[c*POS_W +: POS_W]), int'(ep));
        end
`endif
        if (rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                logic [1:0] cur;
                int d;
                cur = quad[2*c +: 2];
                if (cur != prev_q[c]) begin
                    d = (qidx(cur) - qidx(prev_q[c]) + 4) % 4;
                    check("quad_onebit", int'(d != 2), 1);
                    obs_steps[c]++;
                    if (d == 1) obs_net[c]++;
                    if (d == 3) obs_net[c]--;
                    prev_q[c] = cur;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        if (rst_n) model_edge();
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        #1;
        check("rst_quad", int'(quad), 4'hF);
        check("rst_busy", int'(busy), 0);
        run(2);
        rst_n = 1'b1;
    endtask

    task automatic toggle(input int c, input int dx);
        mouse_dx[c*DX_W +: DX_W] = DX_W'(dx);
        mouse_tgl[c] = ~mouse_tgl[c];
        tick();
    endtask

    initial begin
        vecs[0] = '{ch: 0, dx:    3, steps:   3, fin: 2'b10};
        vecs[1] = '{ch: 0, dx:   -1, steps:   1, fin: 2'b10};
        vecs[2] = '{ch: 1, dx:    4, steps:   4, fin: 2'b11};
        vecs[3] = '{ch: 1, dx:   -6, steps:   6, fin: 2'b00};
        vecs[4] = '{ch: 0, dx:    1, steps:   1, fin: 2'b01};
        vecs[5] = '{ch: 1, dx:    0, steps:   0, fin: 2'b11};
        vecs[6] = '{ch: 0, dx: -256, steps: 256, fin: 2'b11};

        #2;
        do_reset();

        // Single mouse packets from a fresh reset
        foreach (vecs[i]) begin
            int mag;
            do_reset();
            run(3);
            toggle(vecs[i].ch, vecs[i].dx);
            mag = (vecs[i].dx < 0) ? -vecs[i].dx : vecs[i].dx;
            run((mag + 2) * STEP_DIV + 4);
            check("vec_steps", obs_steps[vecs[i].ch], vecs[i].steps);
            check("vec_net", obs_net[vecs[i].ch], vecs[i].dx);
            check("vec_quad", int'(quad[2*vecs[i].ch +: 2]), int'(vecs[i].fin));
            check("vec_busy", int'(busy), 0);
            $display("vector %0d ch%0d dx=%0d steps=%0d quad=%b", i, vecs[i].ch, vecs[i].dx,
                     obs_steps[vecs[i].ch], quad[2*vecs[i].ch +: 2]);
        end

        // Reversal discards the pending positive motion
        do_reset();
        run(3);
        toggle(0, 100);
        begin
            int n = 0;
            while (obs_steps[0] < 5 && n < 20 * STEP_DIV) begin
                tick();
                n++;
            end
        end
        check("t2_first_steps", obs_steps[0], 5);
        toggle(0, -2);
        run(5 * STEP_DIV);
        check("t2_steps", obs_steps[0], 7);
        check("t2_net", obs_net[0], 3);
        check("t2_busy", int'(busy[0]), 0);
        $display("reversal: steps=%0d net=%0d", obs_steps[0], obs_net[0]);

        // Back-to-back packets every cycle block all steps; accumulator saturates
        do_reset();
        run(3);
        for (int i = 0; i < 20; i++) toggle(0, 255);
        tick();
        check("t3_busy", int'(busy[0]), 1);
        check("t3_no_steps", obs_steps[0], 0);
        run((ACC_LIM + 2) * STEP_DIV);
        check("t3_drain_steps", obs_steps[0], ACC_LIM);
        check("t3_drain_net", obs_net[0], ACC_LIM);
        check("t3_idle", int'(busy[0]), 0);
        $display("saturation: drained %0d steps", obs_steps[0]);

        // Joystick loads, both-held priority and release
        do_reset();
        run(3);
        joy_pos[1]  = 1'b1;
        joy_fast[1] = 1'b1;
        run(POLL_DIV - 1);
        check("t4_preload", int'(busy[1]), 0);
        run(1);
        check("t4_load", int'(busy[1]), 1);
        run(POLL_DIV);
        check("t4_period", obs_steps[1], JOY_STEP_FAST);
        check("t4_reload", int'(busy[1]), 1);
        joy_neg[1] = 1'b1;
        run(POLL_DIV);
        check("t4_both", obs_net[1], 2 * JOY_STEP_FAST);
        joy_pos[1]  = 1'b0;
        joy_neg[1]  = 1'b0;
        joy_fast[1] = 1'b0;
        run(POLL_DIV + 50);
        check("t4_release_net", obs_net[1], 3 * JOY_STEP_FAST);
        check("t4_release_steps", obs_steps[1], 3 * JOY_STEP_FAST);
        check("t4_release_busy", int'(busy[1]), 0);
        $display("joystick: net=%0d", obs_net[1]);

        // Mouse event landing on the joystick load edge is ignored
        do_reset();
        run(3);
        joy_pos[0] = 1'b1;
        for (int i = 1; i <= POLL_DIV; i++) begin
            if (i == POLL_DIV - 1) toggle(0, 50);
            else tick();
        end
        joy_pos[0] = 1'b0;
        check("t5_load_busy", int'(busy[0]), 1);
        run(10 * STEP_DIV);
        check("t5_collide_steps", obs_steps[0], JOY_STEP);
        check("t5_collide_net", obs_net[0], JOY_STEP);
        $display("collision: steps=%0d", obs_steps[0]);

        // Reset mid-burst, then toggles already high at reset release
        toggle(0, 100);
        run(40);
        mouse_tgl = '1;
        mouse_dx  = {NUM_CH{DX_W'(5)}};
        do_reset();
        run(10 * STEP_DIV);
        check("t5_release_steps", obs_steps[0] + obs_steps[1], 0);
        check("t5_release_busy", int'(busy), 0);
        $display("reset release: steps=%0d", obs_steps[0] + obs_steps[1]);

`ifdef SPINNER_ABSPOS_EN
        do_reset();
        run(3);
        toggle(0, 17);
        run(19 * STEP_DIV + 4);
        check("t6_abs_wrap", int'(abs_pos[POS_W-1:0]), 1);
        toggle(0, -2);
        run(4 * STEP_DIV + 4);
        check("t6_abs_neg", int'(abs_pos[POS_W-1:0]), 15);
        $display("abs_pos: %h", abs_pos[POS_W-1:0]);
`endif

        // Randomized traffic against the model, with a reset in the middle
        do_reset();
        run(3);
        for (int i = 0; i < 8000; i++) begin
            if (i == 4000) begin
                do_reset();
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 19) == 0) begin
                    mouse_dx[c*DX_W +: DX_W] = DX_W'($urandom_range(0, 511));
                    mouse_tgl[c] = ~mouse_tgl[c];
                end
                if ($urandom_range(0, 299) == 0) begin
                    joy_pos[c]  = ($urandom_range(0, 2) == 0);
                    joy_neg[c]  = ($urandom_range(0, 2) == 0);
                    joy_fast[c] = $urandom_range(0, 1) != 0;
                end
            end
            tick();
        end
        $display("random: ch0 steps=%0d ch1 steps=%0d", obs_steps[0], obs_steps[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
